uart_rx_reader: RTL

UART receiver: the counterpart of uart_tx_writer on the same serial link (8N1, LSB first, idle high).
- Synchronises the asynchronous rx line into the clk domain.
- Detects a start bit and samples each bit at its midpoint.
- Delivers each received byte with a one-cycle valid pulse.
- Flags a missing stop bit as a framing error.
- Sits at the FPGA pin side, feeding a byte consumer.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_bit_sync.sv | 24 ++
 rtl/uart_rx_reader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame width, bit-period helper.
// Used by uart_rx_reader and uart_tx_writer.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    function automatic int clks_per_bit(
        input int clk_freq,
        input int boadrate
    );
        return clk_freq / boadrate;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for an asynchronous pin input.
// RST_VAL selects the level the chain holds in reset (idle level of the pin).
module uart_bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_reader.sv
// UART receiver, 8N1 LSB first; define UART_RX_PARITY_EN for 8E1 framing.
// Samples each bit at its midpoint after a two-flop synchroniser.
module uart_rx_reader
    import uart_pkg::*;
#(
    parameter int clk_freq = 50_000_000,
    parameter int boadrate = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(clk_freq, boadrate);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
    logic           bit_end, half_end;
`ifdef UART_RX_PARITY_EN
    logic           perr_q, perr_d;
    logic           par_bad_q, par_bad_d;
`endif

    uart_bit_sync #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rx),
        .q_o(rx_s)
    );

    assign bit_end  = (cnt_q == BIT_LAST);
    assign half_end = (cnt_q == HALF_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    cnt_d     = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            START: begin
                if (half_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A high midpoint means the edge was a glitch.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_s != ^shift_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_IDLE: begin
                // A held-low break produces one error, not a stream of frames.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
    assign busy       = (state_q != IDLE) | valid_q | perr_q;
`else
    assign parity_err = 1'b0;
    assign busy       = (state_q != IDLE) | valid_q;
`endif

endmodule
